// File: rtl/sram32_arb_if.sv
// Bundle of the fetch port, data port and sram32 strobe signals around sram32_arb.
// slave = arbiter side, master = requesters plus SRAM side.
interface sram32_arb_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_ack;
  logic [31:0]           d_rdata;

  logic                  busy;

  logic                  sram_rd;
  logic                  sram_we;
  logic [3:0]            sram_byte_en;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, busy,
           sram_rd, sram_we, sram_byte_en, sram_addr, sram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, busy,
           sram_rd, sram_we, sram_byte_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram32_arb.sv
// Round-robin arbiter sharing one sram32 between a read-only fetch port and a
// read/write data port; every output is driven straight from a flop.
module sram32_arb #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  sram32_arb_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1 = data port won the last grant
  logic                  gnt_d_q, gnt_d_d;     // port owning the current transaction
  logic                  grant_i;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic                  busy_q, busy_d;
  logic                  sram_rd_q, sram_rd_d;
  logic                  sram_we_q, sram_we_d;
  logic [3:0]            sram_be_q, sram_be_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]           sram_wdata_q, sram_wdata_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d      = state_q;
    last_d_d     = last_d_q;
    gnt_d_d      = gnt_d_q;
    grant_i      = 1'b0;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    sram_rd_d    = sram_rd_q;
    sram_we_d    = sram_we_q;
    sram_be_d    = sram_be_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie the port that did not win last time goes first.
          grant_i  = bus.i_req && (!bus.d_req || last_d_q);
          state_d  = ST_ACCESS;
          gnt_d_d  = !grant_i;
          last_d_d = !grant_i;
          if (grant_i) begin
            sram_addr_d = bus.i_addr;
            sram_rd_d   = 1'b1;
            sram_we_d   = 1'b0;
            sram_be_d   = 4'h0;
          end else begin
            sram_addr_d  = bus.d_addr;
            sram_rd_d    = !bus.d_we;
            sram_we_d    = bus.d_we;
            sram_be_d    = bus.d_we ? bus.d_be : 4'h0;
            sram_wdata_d = bus.d_wdata;
          end
        end
      end
      ST_ACCESS: begin
        sram_rd_d = 1'b0;
        sram_we_d = 1'b0;
        sram_be_d = 4'h0;
        if (sram_we_q) begin
          state_d = ST_RESP;
          d_ack_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        if (gnt_d_q) begin
          d_rdata_d = bus.sram_rdata;
          d_ack_d   = 1'b1;
        end else begin
          i_rdata_d = bus.sram_rdata;
          i_ack_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and state updates use non-blocking assignments only.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_d_q     <= 1'b1;
      gnt_d_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      sram_rd_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= 4'h0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      gnt_d_q      <= gnt_d_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
      sram_rd_q    <= sram_rd_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.i_ack        = i_ack_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_ack        = d_ack_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.busy         = busy_q;
  assign bus.sram_rd      = sram_rd_q;
  assign bus.sram_we      = sram_we_q;
  assign bus.sram_byte_en = sram_be_q;
  assign bus.sram_addr    = sram_addr_q;
  assign bus.sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_sram32_arb.sv
// Bench for sram32_arb: behavioural sram32, directed requesters, and a scoreboard
// monitor that pops one expected ack per observed ack.
module tb_sram32_arb;
  localparam int AW = 11;

  typedef struct {
    bit          is_d;
    bit          has_data;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic preload;

  always #5 clk = ~clk;

  sram32_arb_if #(.ADDR_WIDTH(AW)) bus ();

  sram32_arb #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   busy_low = 0;
  exp_t sb_q[$];

  // Behavioural sram32: byte-enabled write, read data valid the cycle after rd.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (preload) begin
      mem[11'h000] <= 32'h1111_1111;
      mem[11'h001] <= 32'h2222_2222;
      mem[11'h002] <= 32'h3333_3333;
      mem[11'h003] <= 32'h4444_4444;
      mem[11'h005] <= 32'h0000_0000;
      mem[11'h010] <= 32'hA5A5_A5A5;
      mem[11'h020] <= 32'h0F0F_0F0F;
      mem[11'h7FF] <= 32'h0000_0000;
    end else begin
      if (bus.sram_we)
        for (int b = 0; b < 4; b++)
          if (bus.sram_byte_en[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      if (bus.sram_rd) bus.sram_rdata <= mem[bus.sram_addr];
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.sram_we) we_cnt++;
    if (!bus.busy) busy_low++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_ack || bus.d_ack) begin
      check("ack_exclusive", {31'h0, bus.i_ack & bus.d_ack}, 32'h0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'h0, bus.i_ack, bus.d_ack}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", {31'h0, bus.d_ack}, {31'h0, e.is_d});
        if (e.has_data)
          check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.data);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input bit is_d, input bit we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    if (is_d) begin
      bus.d_we    = we;
      bus.d_be    = be;
      bus.d_addr  = addr;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
    end else begin
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
    end
  endtask

  // Counts edges from request presentation until the ack is seen.
  task automatic wait_ack(input bit is_d, output int n);
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = is_d ? bus.d_ack : bus.i_ack;
    end
    check("ack_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic xact(input bit is_d, input bit we, input logic [3:0] be,
                      input logic [AW-1:0] addr, input logic [31:0] wd,
                      input bit has_data, input logic [31:0] exp_data,
                      input int exp_lat, output int ack_cyc);
    exp_t e;
    int   n, b0, w0;
    e = '{is_d, has_data, exp_data};
    sb_q.push_back(e);
    b0 = busy_low;
    w0 = we_cnt;
    issue(is_d, we, be, addr, wd);
    wait_ack(is_d, n);
    ack_cyc = cyc;
    check("latency", n, exp_lat);
    check("busy_low_cycles", busy_low - b0, 1);
    if (is_d && we) check("sram_we_pulses", we_cnt - w0, 1);
    @(posedge clk);
    #1;
    if (is_d) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
  endtask

  initial begin
    int   ac, prev, acks, guard;
    bit   seq [8];
    exp_t e;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = '0;  bus.d_wdata = 32'h0;
    preload = 1'b1;
    do_reset();
    preload = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_i_ack", {31'h0, bus.i_ack}, 32'h0);
    check("rst_d_ack", {31'h0, bus.d_ack}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_strobes", {29'h0, bus.sram_rd, bus.sram_we, |bus.sram_byte_en}, 32'h0);
    check("rst_sram_addr", {21'h0, bus.sram_addr}, 32'h0);
    check("rst_sram_wdata", bus.sram_wdata, 32'h0);
    check("rst_i_rdata", bus.i_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Full write, fetch back, byte-lane write, zero-enable write
    xact(1, 1, 4'hF, 11'h005, 32'hDEAD_BEEF, 0, 32'h0, 2, ac);
    xact(0, 0, 4'h0, 11'h005, 32'h0, 1, 32'hDEAD_BEEF, 3, ac);
    xact(1, 1, 4'b0010, 11'h005, 32'h0000_5500, 0, 32'h0, 2, ac);
    xact(1, 0, 4'h0, 11'h005, 32'h0, 1, 32'hDEAD_55EF, 3, ac);
    xact(1, 1, 4'h0, 11'h005, 32'hFFFF_FFFF, 0, 32'h0, 2, ac);
    xact(1, 0, 4'hF, 11'h005, 32'h0, 1, 32'hDEAD_55EF, 3, ac);

    // Both ports requesting from reset: fetch first, then strict alternation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      e = '{1'b0, 1'b1, 32'hA5A5_A5A5};
      sb_q.push_back(e);
      e = '{1'b1, 1'b1, 32'h0F0F_0F0F};
      sb_q.push_back(e);
    end
    issue(0, 0, 4'h0, 11'h010, 32'h0);
    issue(1, 0, 4'hF, 11'h020, 32'h0);
    acks  = 0;
    guard = 0;
    while (acks < 8 && guard < 100) begin
      @(posedge clk);
      guard++;
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        seq[acks] = bus.d_ack;
        acks++;
      end
    end
    check("alt_ack_count", acks, 8);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    for (int k = 0; k < 8; k++) check("alt_order", {31'h0, seq[k]}, k % 2);

    // Fetch streaming at 0x000..0x003
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: xact(0, 0, 4'h0, 11'h000, 32'h0, 1, 32'h1111_1111, 3, ac);
        1: xact(0, 0, 4'h0, 11'h001, 32'h0, 1, 32'h2222_2222, 3, ac);
        2: xact(0, 0, 4'h0, 11'h002, 32'h0, 1, 32'h3333_3333, 3, ac);
        default: xact(0, 0, 4'h0, 11'h003, 32'h0, 1, 32'h4444_4444, 3, ac);
      endcase
      if (k > 0) check("stream_ack_gap", ac - prev, 4);
      prev = ac;
    end

    // Reset during WAIT of a data read
    issue(1, 0, 4'hF, 11'h001, 32'h0);
    @(posedge clk);            // grant
    @(posedge clk);            // ACCESS -> WAIT
    #1;
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wait_rst_d_ack", {31'h0, bus.d_ack}, 32'h0);
    check("wait_rst_d_rdata", bus.d_rdata, 32'h0);
    check("wait_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("wait_rst_strobes", {29'h0, bus.sram_rd, bus.sram_we, |bus.sram_byte_en}, 32'h0);
    @(negedge clk);
    check("wait_rst_d_ack_late", {31'h0, bus.d_ack}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    xact(1, 0, 4'hF, 11'h002, 32'h0, 1, 32'h3333_3333, 3, ac);

    // Reset during ACCESS of a write: SRAM still commits it
    issue(1, 1, 4'hF, 11'h7FF, 32'h1234_5678);
    @(posedge clk);            // grant -> ACCESS
    #1;
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("acc_rst_d_ack", {31'h0, bus.d_ack}, 32'h0);
    check("acc_rst_sram_we", {31'h0, bus.sram_we}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    xact(0, 0, 4'h0, 11'h7FF, 32'h0, 1, 32'h1234_5678, 3, ac);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
